scope_trace_plotter: RTL and testbench

//  Pixel-write source feeding the VGA LCD driver's user interface (X, Y, WR, RGB).
//  On START it clears the plot area, overlaying a graticule while it clears.
//  It then accepts one sample per screen column and draws the waveform as

---
 rtl/scope_plot_pkg.sv | 19 +
 rtl/scope_span_gen.sv | 34 +++
 rtl/scope_trace_plotter.sv | 204 ++++++++++++++++++++
 tb/tb_scope_trace_plotter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/scope_plot_pkg.sv
// Shared encodings and widths for the scope trace plotter and its span generator.
package scope_plot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT,
        ST_DRAW
    } plot_state_t;

    localparam int X_W = 10;
    localparam int Y_W = 9;

    localparam int         COLOR_W_DEF     = 3;
    localparam logic [2:0] BG_COLOR_DEF    = 3'b000;
    localparam logic [2:0] GRID_COLOR_DEF  = 3'b010;
    localparam logic [2:0] TRACE_COLOR_DEF = 3'b110;

endpackage

// File: rtl/scope_span_gen.sv
// Walks rows from min(y_a,y_b) to max(y_a,y_b); row/last are valid in the load
// cycle itself so the caller can register the first row on the load edge.
module scope_span_gen
    import scope_plot_pkg::*;
(
    input  logic           clk,
    input  logic           load,
    input  logic           step,
    input  logic [Y_W-1:0] y_a,
    input  logic [Y_W-1:0] y_b,
    output logic [Y_W-1:0] row,
    output logic           last
);

    logic [Y_W-1:0] lo;
    logic [Y_W-1:0] hi;
    logic [Y_W-1:0] row_q;
    logic [Y_W-1:0] hi_q;

    assign lo   = (y_a < y_b) ? y_a : y_b;
    assign hi   = (y_a < y_b) ? y_b : y_a;
    assign row  = load ? lo : row_q;
    assign last = load ? (lo == hi) : (row_q == hi_q);

    always_ff @(posedge clk) begin
        if (load) begin
            row_q <= lo + Y_W'(1);
            hi_q  <= hi;
        end else if (step) begin
            row_q <= row_q + Y_W'(1);
        end
    end

endmodule

// File: rtl/scope_trace_plotter.sv
// Pixel-write source for the VGA LCD user port: clears the plot with a graticule,
// then draws one vertical span per accepted sample column.
module scope_trace_plotter
    import scope_plot_pkg::*;
#(
    parameter int                 H_RES       = 640,
    parameter int                 V_RES       = 480,
    parameter int                 SAMPLE_W    = 8,
    parameter int                 Y_BASE      = 367,
    parameter int                 GRID_X      = 64,
    parameter int                 GRID_Y      = 60,
    parameter int                 COLOR_W     = COLOR_W_DEF,
    parameter logic [COLOR_W-1:0] BG_COLOR    = COLOR_W'(BG_COLOR_DEF),
    parameter logic [COLOR_W-1:0] GRID_COLOR  = COLOR_W'(GRID_COLOR_DEF),
    parameter logic [COLOR_W-1:0] TRACE_COLOR = COLOR_W'(TRACE_COLOR_DEF)
) (
    input  logic                CLOCK_25,
    input  logic                RESET,
    input  logic                START,
    input  logic [SAMPLE_W-1:0] S_DATA,
    input  logic                S_VALID,
    output logic                S_READY,
    output logic [X_W-1:0]      X,
    output logic [Y_W-1:0]      Y,
    output logic                WR,
    output logic [COLOR_W-1:0]  RGB,
    output logic                BUSY,
    output logic                DONE
);

    localparam logic [X_W-1:0] X_LAST  = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST  = Y_W'(V_RES - 1);
    localparam logic [X_W-1:0] GX_LAST = X_W'(GRID_X - 1);
    localparam logic [Y_W-1:0] GY_LAST = Y_W'(GRID_Y - 1);

    // Extra bit catches an underflow that legal parameters never produce.
    function automatic logic [Y_W-1:0] sample_to_row(input logic [SAMPLE_W-1:0] s);
        logic [Y_W:0] d;
        d = (Y_W+1)'(Y_BASE) - (Y_W+1)'(s);
        return d[Y_W] ? '0 : d[Y_W-1:0];
    endfunction

    plot_state_t        state, state_nxt;
    logic [X_W-1:0]     x_q, x_nxt;
    logic [Y_W-1:0]     y_q, y_nxt;
    logic               wr_q, wr_nxt;
    logic [COLOR_W-1:0] rgb_q, rgb_nxt;
    logic               s_ready_q, s_ready_nxt;
    logic               busy_q, busy_nxt;
    logic               done_q, done_nxt;
    logic [X_W-1:0]     cx, cx_nxt, gx, gx_nxt, col, col_nxt;
    logic [Y_W-1:0]     cy, cy_nxt, gy, gy_nxt;
    logic [Y_W-1:0]     y_prev_q, y_prev_nxt, y_cur_q, y_cur_nxt;
    logic [Y_W-1:0]     y_new, span_a, span_b, span_row;
    logic               span_load, span_step, span_last;
    logic               emit_clear, emit_span;

    assign y_new  = sample_to_row(S_DATA);
    assign span_b = (state == ST_WAIT) ? y_new : y_cur_q;
    assign span_a = (state == ST_WAIT && col == '0) ? y_new : y_prev_q;

    scope_span_gen u_span (
        .clk  (CLOCK_25),
        .load (span_load),
        .step (span_step),
        .y_a  (span_a),
        .y_b  (span_b),
        .row  (span_row),
        .last (span_last)
    );

    always_comb begin
        state_nxt   = state;
        x_nxt       = x_q;
        y_nxt       = y_q;
        wr_nxt      = 1'b0;
        rgb_nxt     = rgb_q;
        s_ready_nxt = 1'b0;
        busy_nxt    = busy_q;
        done_nxt    = 1'b0;
        cx_nxt      = cx;
        cy_nxt      = cy;
        gx_nxt      = gx;
        gy_nxt      = gy;
        col_nxt     = col;
        y_prev_nxt  = y_prev_q;
        y_cur_nxt   = y_cur_q;
        span_load   = 1'b0;
        span_step   = 1'b0;
        emit_clear  = 1'b0;
        emit_span   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                // IDLE with BUSY still set is the cycle right after the final column.
                busy_nxt = 1'b0;
                done_nxt = busy_q;
                if (START && !busy_q) begin
                    busy_nxt   = 1'b1;
                    emit_clear = 1'b1;
                    state_nxt  = ST_CLEAR;
                end
            end
            ST_CLEAR: emit_clear = 1'b1;
            ST_WAIT: begin
                s_ready_nxt = 1'b1;
                if (S_VALID && s_ready_q) begin
                    s_ready_nxt = 1'b0;
                    span_load   = 1'b1;
                    emit_span   = 1'b1;
                    y_cur_nxt   = y_new;
                end
            end
            ST_DRAW: begin
                span_step = 1'b1;
                emit_span = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (emit_clear) begin
            x_nxt   = cx;
            y_nxt   = cy;
            wr_nxt  = 1'b1;
            rgb_nxt = (gx == '0 || gy == '0) ? GRID_COLOR : BG_COLOR;
            if (cx == X_LAST) begin
                cx_nxt = '0;
                gx_nxt = '0;
                if (cy == Y_LAST) begin
                    cy_nxt    = '0;
                    gy_nxt    = '0;
                    col_nxt   = '0;
                    state_nxt = ST_WAIT;
                end else begin
                    cy_nxt = cy + Y_W'(1);
                    gy_nxt = (gy == GY_LAST) ? '0 : gy + Y_W'(1);
                end
            end else begin
                cx_nxt = cx + X_W'(1);
                gx_nxt = (gx == GX_LAST) ? '0 : gx + X_W'(1);
            end
        end

        if (emit_span) begin
            x_nxt   = col;
            y_nxt   = span_row;
            wr_nxt  = 1'b1;
            rgb_nxt = TRACE_COLOR;
            if (span_last) begin
                y_prev_nxt = span_b;
                col_nxt    = (col == X_LAST) ? '0 : col + X_W'(1);
                state_nxt  = (col == X_LAST) ? ST_IDLE : ST_WAIT;
            end else begin
                state_nxt = ST_DRAW;
            end
        end
    end

    always_ff @(posedge CLOCK_25) begin
        if (RESET) begin
            state     <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            wr_q      <= 1'b0;
            rgb_q     <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cx        <= '0;
            cy        <= '0;
            gx        <= '0;
            gy        <= '0;
            col       <= '0;
        end else begin
            state     <= state_nxt;
            x_q       <= x_nxt;
            y_q       <= y_nxt;
            wr_q      <= wr_nxt;
            rgb_q     <= rgb_nxt;
            s_ready_q <= s_ready_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            cx        <= cx_nxt;
            cy        <= cy_nxt;
            gx        <= gx_nxt;
            gy        <= gy_nxt;
            col       <= col_nxt;
        end
    end

    always_ff @(posedge CLOCK_25) begin
        y_prev_q <= y_prev_nxt;
        y_cur_q  <= y_cur_nxt;
    end

    assign X       = x_q;
    assign Y       = y_q;
    assign WR      = wr_q;
    assign RGB     = rgb_q;
    assign S_READY = s_ready_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_scope_trace_plotter.sv
// Directed bench for scope_trace_plotter on a small 8x6 plot with a pixel scoreboard.
module tb_scope_trace_plotter;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [2:0] rgb;
    } pix_t;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic [1:0] S_DATA = '0;
    logic       S_VALID = 1'b0;
    logic       S_READY;
    logic [9:0] X;
    logic [8:0] Y;
    logic       WR;
    logic [2:0] RGB;
    logic       BUSY;
    logic       DONE;

    int   n_assert = 0;
    int   n_fail = 0;
    pix_t exp_q[$];
    pix_t mon_e;
    int   col_m = 0;
    int   yprev_m = 0;

    always #20 clk = ~clk;

    scope_trace_plotter #(
        .H_RES(8), .V_RES(6), .SAMPLE_W(2), .Y_BASE(4), .GRID_X(4), .GRID_Y(4)
    ) dut (
        .CLOCK_25(clk), .RESET(RESET), .START(START), .S_DATA(S_DATA),
        .S_VALID(S_VALID), .S_READY(S_READY), .X(X), .Y(Y), .WR(WR),
        .RGB(RGB), .BUSY(BUSY), .DONE(DONE)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_pix(input int x, input int y, input logic [2:0] c);
        pix_t p;
        p.x = 10'(x);
        p.y = 9'(y);
        p.rgb = c;
        exp_q.push_back(p);
    endfunction

    // Scoreboard: every write must match the oldest expected pixel.
    always @(negedge clk) begin
        if (WR === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wr", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check("pixel", 32'({X, Y, RGB}), 32'(mon_e));
            end
        end
    end

    task automatic do_clear();
        for (int y = 0; y < 6; y++)
            for (int x = 0; x < 8; x++)
                push_pix(x, y, ((x % 4 == 0) || (y % 4 == 0)) ? 3'b010 : 3'b000);
        col_m = 0;
        @(posedge clk); #1 START = 1'b1;
        @(posedge clk); #1 START = 1'b0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            check("clear_wr_busy", {30'd0, WR, BUSY}, 32'd3);
            if (i == 47) check("ready_low_last_px", 32'(S_READY), 32'd0);
        end
        @(negedge clk);
        check("ready_after_clear", {30'd0, S_READY, WR}, 32'd2);
        check("clear_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (S_READY === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("ready_timeout", 32'(ok), 32'd1);
    endtask

    task automatic send(input int v);
        int ycur, lo, hi;
        ycur = 4 - v;
        if (col_m == 0) yprev_m = ycur;
        lo = (yprev_m < ycur) ? yprev_m : ycur;
        hi = (yprev_m < ycur) ? ycur : yprev_m;
        for (int r = lo; r <= hi; r++) push_pix(col_m, r, 3'b110);
        yprev_m = ycur;
        col_m++;
        wait_ready();
        S_DATA = 2'(v);
        S_VALID = 1'b1;
        @(posedge clk); #1 S_VALID = 1'b0;
    endtask

    task automatic finish_frame();
        int dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (DONE === 1'b1) dones++;
        end
        check("done_pulses", 32'(dones), 32'd1);
        check("busy_after_done", 32'(BUSY), 32'd0);
        check("frame_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_x", 32'(X), 32'd0);
        check("rst_y", 32'(Y), 32'd0);
        check("rst_wr", 32'(WR), 32'd0);
        check("rst_rgb", 32'(RGB), 32'd0);
        check("rst_ready", 32'(S_READY), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        @(posedge clk); #1 RESET = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_no_wr", 32'(WR), 32'd0);

        // Frame 1: clear, samples 0 and 3, stall, then fill remaining columns
        do_clear();
        send(0);
        send(3);
        wait_ready();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stall_ready_nowr", {30'd0, S_READY, WR}, 32'd2);
        end
        for (int i = 0; i < 6; i++) send(2);
        finish_frame();

        // Frame 2: eight flat samples with a START pulse mid-frame
        do_clear();
        for (int i = 0; i < 8; i++) begin
            send(2);
            if (i == 2) begin
                START = 1'b1;
                @(posedge clk); #1 START = 1'b0;
            end
        end
        finish_frame();

        // Frame 3: reset in the middle of a 4-row span
        do_clear();
        send(0);
        wait_ready();
        push_pix(1, 1, 3'b110);
        push_pix(1, 2, 3'b110);
        S_DATA = 2'd3;
        S_VALID = 1'b1;
        @(posedge clk); #1 S_VALID = 1'b0;
        @(negedge clk);
        check("span_row1", {22'd0, WR, Y}, {22'd0, 1'b1, 9'd1});
        @(posedge clk); #1 RESET = 1'b1;
        @(negedge clk);
        check("span_row2", {22'd0, WR, Y}, {22'd0, 1'b1, 9'd2});
        @(negedge clk);
        check("abort_wr", 32'(WR), 32'd0);
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_ready", 32'(S_READY), 32'd0);
        check("abort_done", 32'(DONE), 32'd0);
        @(posedge clk); #1 RESET = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_drained", 32'(exp_q.size()), 32'd0);
        do_clear();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
